// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared types and default constants for the clock divider bank.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int MODE_W          = 2;
    localparam int NUM_CH_DEF      = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_LIM_DEF = 49999;

    typedef enum logic [MODE_W-1:0] {
        MODE_TOGGLE  = 2'd0,
        MODE_PULSE   = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Brief    : One divider channel: counter, terminal limit, mode and outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_LIM = DEFAULT_LIM_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_lim_i,
    input  mode_e            wr_mode_i,
    output logic             div_o,
    output logic             tick_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    mode_e            mode_q, mode_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        lim_d  = lim_q;
        mode_d = mode_q;
        div_d  = div_q;
        tick_d = 1'b0;
        done_d = done_q;
        if (wr_i) begin
            lim_d  = wr_lim_i;
            mode_d = wr_mode_i;
            cnt_d  = '0;
            div_d  = 1'b0;
            done_d = 1'b0;
        end else if (!en_i) begin
            // A low enable rearms a finished one-shot; otherwise the count just pauses.
            if (done_q) begin
                done_d = 1'b0;
                div_d  = 1'b0;
                cnt_d  = '0;
            end else if (mode_q == MODE_PULSE) begin
                div_d = 1'b0;
            end
        end else if (!done_q) begin
            if (cnt_q == lim_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    MODE_PULSE:   div_d = 1'b1;
                    MODE_ONESHOT: begin
                        div_d  = 1'b1;
                        done_d = 1'b1;
                    end
                    default:      div_d = ~div_q;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mode_q == MODE_PULSE) begin
                    div_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lim_q  <= CNT_W'(DEFAULT_LIM);
            mode_q <= MODE_TOGGLE;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            mode_q <= mode_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign div_o  = div_q;
    assign tick_o = tick_q;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : Bank of independent programmable clock-divider channels.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_LIM = DEFAULT_LIM_DEF
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_CH-1:0]                              en_i,
    input  logic                                           cfg_we_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [CNT_W-1:0]                               cfg_lim_i,
    input  logic [MODE_W-1:0]                              cfg_mode_i,
    output logic [NUM_CH-1:0]                              div_o,
    output logic [NUM_CH-1:0]                              tick_o,
    output logic [NUM_CH-1:0]                              done_o
);

    if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_bad_num_ch
        $error("clk_div_bank: NUM_CH must be within 1..32");
    end

    if ((DEFAULT_LIM < 0) || (longint'(DEFAULT_LIM) >= (longint'(1) << CNT_W))) begin : g_bad_lim
        $error("clk_div_bank: DEFAULT_LIM does not fit in CNT_W bits");
    end

    logic [NUM_CH-1:0] w_wr_sel;
    mode_e             w_wr_mode;

    assign w_wr_mode = mode_e'(cfg_mode_i);

    // Channel indices at or above NUM_CH never match, so such writes fall away.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we_i && (32'(cfg_ch_i) == i)) begin
                w_wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_LIM (DEFAULT_LIM)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en_i[g]),
            .wr_i      (w_wr_sel[g]),
            .wr_lim_i  (cfg_lim_i),
            .wr_mode_i (w_wr_mode),
            .div_o     (div_o[g]),
            .tick_o    (tick_o[g]),
            .done_o    (done_o[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent divider channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, meaning counter and limit width in bits.
REQ-003 SHALL have parameter DEFAULT_LIM, default 49999, meaning per-channel limit after reset; elaboration error if DEFAULT_LIM >= 2**CNT_W.
REQ-004 SHALL have port clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en_i  input  NUM_CH  per-channel count enable.
REQ-007 SHALL have port cfg_we_i  input  1  single-cycle configuration write strobe.
REQ-008 SHALL have port cfg_ch_i  input  $clog2(NUM_CH) (min 1)  target channel of write.
REQ-009 SHALL have port cfg_lim_i  input  CNT_W  new terminal count for target channel.
REQ-010 SHALL have port cfg_mode_i  input  2  new mode (mode_e) for target channel.
REQ-011 SHALL have port div_o  output  NUM_CH  per-channel divided output.
REQ-012 SHALL have port tick_o  output  NUM_CH  per-channel one-cycle wrap pulse.
REQ-013 SHALL have port done_o  output  NUM_CH  per-channel one-shot complete flag.

Function
REQ-014 SHALL keep per channel: cnt (CNT_W), lim (CNT_W), mode (mode_e), div, tick, done registers; all outputs driven directly from registers.
REQ-015 SHALL support modes: MODE_TOGGLE=0, MODE_PULSE=1, MODE_ONESHOT=2; value 3 reserved, treated as MODE_TOGGLE.
REQ-016 SHALL, when en_i[i]=1, done=0 and cnt!=lim, increment cnt by 1 (no wrap arithmetic beyond lim).
REQ-017 SHALL, when en_i[i]=1, done=0 and cnt==lim, load cnt=0 and set tick=1 for the next cycle only (wrap event).
REQ-018 SHALL give tick period of exactly lim+1 cycles under constant enable; lim=0 gives tick every cycle.
REQ-019 SHALL in MODE_TOGGLE invert div on each wrap event (output period 2*(lim+1) cycles, 50% duty).
REQ-020 SHALL in MODE_PULSE drive div identical to tick.
REQ-021 SHALL in MODE_ONESHOT on first wrap set tick=1 for one cycle, set done=1 and div=1, and stop counting (cnt held 0) until rearmed.
REQ-022 SHALL rearm a one-shot channel (done=0, div=0, cnt=0) on any cfg write to it, or on en_i[i] being low for at least one cycle.
REQ-023 SHALL, when en_i[i]=0, hold cnt and div, force tick=0; done cleared per REQ-022.
REQ-024 SHALL on cfg_we_i=1 with cfg_ch_i<NUM_CH update lim and mode, clear cnt, div, tick, done of that channel on the same edge; other channels unaffected.
REQ-025 SHALL ignore writes with cfg_ch_i>=NUM_CH.
REQ-026 SHALL give cfg write priority over a simultaneous wrap on the same channel: no tick, no div change.
REQ-027 SHALL start counting with the new lim in the cycle after the write edge if enabled (first tick lim+1 cycles after write).

Reset
REQ-028 SHALL on rst=1 at a clock edge set every cnt=0, lim=DEFAULT_LIM, mode=MODE_TOGGLE, div_o=0, tick_o=0, done_o=0.
REQ-029 SHALL give rst priority over cfg_we_i and en_i; reset mid-count abandons count with no tick.

Structure
REQ-030 SHALL place mode_e typedef, MODE_W=2 and default parameter constants in package clk_div_pkg.
REQ-031 SHALL implement one channel as sub-module clk_div_chan, instantiated NUM_CH times via generate; write decode in clk_div_bank.

Verification
REQ-032 SHALL cover: reset, en_i=all 1, defaults -> ch0 tick every 50000 cycles, div_o[0] toggles every 50000 cycles.
REQ-033 SHALL cover: write ch1 lim=3 mode=PULSE, en high -> tick_o[1]=div_o[1] high 1 cycle every 4 cycles, first 4 cycles after write.
REQ-034 SHALL cover: ch2 lim=5 ONESHOT, en high 20 cycles -> single tick 6 cycles after write, done_o[2]=1 held; en low 1 cycle then high -> second tick 6 cycles later.
REQ-035 SHALL cover: write ch0 lim=2 in same cycle cnt==lim -> no tick that cycle, next tick 3 cycles later; lim=0 -> tick every cycle, div toggles every cycle.
REQ-036 SHALL cover: en_i[3] low 10 cycles mid-count at cnt=7 -> cnt held 7, tick 0, resumes; write cfg_ch_i=NUM_CH -> no state change.
REQ-037 SHALL cover: rst asserted mid-count on all channels -> all outputs 0 next cycle, lim back to DEFAULT_LIM.
